// File: rtl/eth_idma_pkg.sv
// Shared types and defaults for the Ethernet/iDMA multi-channel descriptor scheduler.
// Contents: default channel/queue/in-flight/counter sizes, index-width helper,
//           channel index and status types, default backend request/response payloads.
package eth_idma_pkg;

    localparam int unsigned NumChanDef     = 2;
    localparam int unsigned QueueDepthDef  = 4;
    localparam int unsigned NumInFlightDef = 4;
    localparam int unsigned CntWidthDef    = 16;

    // Index width for n entries; never below one bit so a single channel still has a port.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? 32'($clog2(n)) : 32'd1;
    endfunction

    localparam int unsigned ChanIdxWDef = idx_width(NumChanDef);

    typedef logic [ChanIdxWDef-1:0] chan_idx_t;

    typedef struct packed {
        logic [CntWidthDef-1:0] cnt;
        logic                   err;
    } chan_stat_t;

    // Default 1D backend request payload.
    typedef struct packed {
        logic [31:0] src_addr;
        logic [31:0] dst_addr;
        logic [31:0] length;
    } eth_idma_req_t;

    // Default backend response payload.
    typedef struct packed {
        logic       last;
        logic       error;
        logic [7:0] pld;
    } eth_idma_rsp_t;

endpackage

// File: rtl/eth_idma_fifo.sv
// Registered-output FIFO (no fall-through) used for descriptor queues and the in-flight tracker.
// Ports: clk_i/rst_ni (sync, active-low), push_i/data_i write side, pop_i/data_o read side,
//        empty_o/full_o status. Pushes when full and pops when empty are ignored.
module eth_idma_fifo
    import eth_idma_pkg::*;
#(
    parameter int unsigned Depth = 4,
    parameter type         dtype = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  dtype data_i,
    input  logic pop_i,
    output dtype data_o,
    output logic empty_o,
    output logic full_o
);

    localparam int unsigned PtrW = idx_width(Depth);
    localparam int unsigned CntW = 32'($clog2(Depth + 1));
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

    dtype            mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push;
    logic            do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // Pointers wrap explicitly so non-power-of-two depths work.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/eth_idma_rr_sel.sv
// Round-robin channel selector with lock-in for an AXI-style valid/ready issue port.
// Ports: clk_i/rst_ni (sync, active-low), req_i per-channel request, en_i issue enable,
//        ready_i downstream ready, valid_o issue valid, idx_o winning channel.
// Once valid_o is presented without ready_i, the winner is held until the handshake.
module eth_idma_rr_sel
    import eth_idma_pkg::*;
#(
    parameter int unsigned NumChan = 2,
    parameter int unsigned IdxW    = idx_width(NumChan)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NumChan-1:0] req_i,
    input  logic               en_i,
    input  logic               ready_i,
    output logic               valid_o,
    output logic [IdxW-1:0]    idx_o
);

    logic [IdxW-1:0] ptr_q;
    logic [IdxW-1:0] lock_idx_q;
    logic            lock_q;
    logic [IdxW-1:0] pick;
    logic            found;
    int unsigned     cand;

    // First requesting channel at or after the pointer.
    always_comb begin
        pick  = ptr_q;
        found = 1'b0;
        cand  = 0;
        for (int unsigned i = 0; i < NumChan; i++) begin
            cand = (32'(ptr_q) + i) % NumChan;
            if (!found && req_i[IdxW'(cand)]) begin
                found = 1'b1;
                pick  = IdxW'(cand);
            end
        end
    end

    assign valid_o = en_i & (|req_i);
    assign idx_o   = lock_q ? lock_idx_q : pick;

    // Pointer moves past the winner on handshake; lock holds a stalled winner.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (valid_o && ready_i) begin
            ptr_q  <= (idx_o == IdxW'(NumChan - 1)) ? '0 : idx_o + 1'b1;
            lock_q <= 1'b0;
        end else if (valid_o) begin
            lock_q     <= 1'b1;
            lock_idx_q <= idx_o;
        end else begin
            lock_q <= 1'b0;
        end
    end

endmodule

// File: rtl/eth_idma_chan_sched.sv
// Multi-channel descriptor scheduler in front of a single iDMA backend.
// Ports: clk_i/rst_ni (sync, active-low); chan_req_i/chan_valid_i/chan_ready_o per-channel
//        descriptor queues; idma_req_o/req_valid_o/req_ready_i backend issue;
//        idma_rsp_i/rsp_valid_i/rsp_ready_o backend responses; chan_clear_i, chan_done_cnt_o,
//        chan_err_o, chan_irq_o per-channel status; busy_o any work pending.
// Responses return in issue order, so a FIFO of channel indices routes each completion.
module eth_idma_chan_sched
    import eth_idma_pkg::*;
#(
    parameter int unsigned NumChan     = NumChanDef,
    parameter int unsigned QueueDepth  = QueueDepthDef,
    parameter int unsigned NumInFlight = NumInFlightDef,
    parameter int unsigned CntWidth    = CntWidthDef,
    parameter type         idma_req_t  = eth_idma_req_t,
    parameter type         idma_rsp_t  = eth_idma_rsp_t,
    parameter int unsigned ChanIdxW    = idx_width(NumChan)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  idma_req_t [NumChan-1:0]          chan_req_i,
    input  logic [NumChan-1:0]               chan_valid_i,
    output logic [NumChan-1:0]               chan_ready_o,
    output idma_req_t                        idma_req_o,
    output logic                             req_valid_o,
    input  logic                             req_ready_i,
    input  idma_rsp_t                        idma_rsp_i,
    input  logic                             rsp_valid_i,
    output logic                             rsp_ready_o,
    input  logic [NumChan-1:0]               chan_clear_i,
    output logic [NumChan-1:0][CntWidth-1:0] chan_done_cnt_o,
    output logic [NumChan-1:0]               chan_err_o,
    output logic [NumChan-1:0]               chan_irq_o,
    output logic                             busy_o
);

    idma_req_t                        q_head [NumChan];
    logic [NumChan-1:0]               q_empty;
    logic [NumChan-1:0]               q_full;
    logic [NumChan-1:0]               q_pop;
    logic [ChanIdxW-1:0]              win_idx;
    logic                             issue_hs;
    logic [ChanIdxW-1:0]              trk_head;
    logic                             trk_empty;
    logic                             trk_full;
    logic                             rsp_hs;
    logic [NumChan-1:0]               comp;
    logic [NumChan-1:0][CntWidth-1:0] cnt_q;
    logic [NumChan-1:0]               err_q;
    logic [NumChan-1:0]               irq_q;
    logic                             unused_rsp;

    // Only the error bit of the response is consumed here.
    assign unused_rsp = ^{idma_rsp_i.last, idma_rsp_i.pld};

    // Per-channel descriptor queues.
    for (genvar c = 0; c < NumChan; c++) begin : g_queue
        assign q_pop[c] = issue_hs & (win_idx == ChanIdxW'(c));

        eth_idma_fifo #(
            .Depth (QueueDepth),
            .dtype (idma_req_t)
        ) i_queue (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .push_i  (chan_valid_i[c]),
            .data_i  (chan_req_i[c]),
            .pop_i   (q_pop[c]),
            .data_o  (q_head[c]),
            .empty_o (q_empty[c]),
            .full_o  (q_full[c])
        );
    end

    assign chan_ready_o = ~q_full;

    // Registered tracker-full gates issue, so a same-cycle response cannot free a slot early.
    eth_idma_rr_sel #(
        .NumChan (NumChan),
        .IdxW    (ChanIdxW)
    ) i_rr_sel (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_i   (~q_empty),
        .en_i    (~trk_full),
        .ready_i (req_ready_i),
        .valid_o (req_valid_o),
        .idx_o   (win_idx)
    );

    assign idma_req_o = q_head[win_idx];
    assign issue_hs   = req_valid_o & req_ready_i;

    // In-flight tracker: channel index per outstanding descriptor, in issue order.
    eth_idma_fifo #(
        .Depth (NumInFlight),
        .dtype (logic [ChanIdxW-1:0])
    ) i_tracker (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (issue_hs),
        .data_i  (win_idx),
        .pop_i   (rsp_hs),
        .data_o  (trk_head),
        .empty_o (trk_empty),
        .full_o  (trk_full)
    );

    assign rsp_ready_o = ~trk_empty;
    assign rsp_hs      = rsp_valid_i & ~trk_empty;

    // Completion counter, sticky error and IRQ pulse per channel; clear wins over history
    // but still counts a completion landing in the same cycle.
    for (genvar c = 0; c < NumChan; c++) begin : g_stat
        assign comp[c] = rsp_hs & (trk_head == ChanIdxW'(c));

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                cnt_q[c] <= '0;
                err_q[c] <= 1'b0;
                irq_q[c] <= 1'b0;
            end else begin
                if (chan_clear_i[c]) begin
                    cnt_q[c] <= comp[c] ? CntWidth'(1) : '0;
                    err_q[c] <= comp[c] & idma_rsp_i.error;
                end else if (comp[c]) begin
                    cnt_q[c] <= cnt_q[c] + 1'b1;
                    err_q[c] <= err_q[c] | idma_rsp_i.error;
                end
                irq_q[c] <= comp[c];
            end
        end
    end

    assign chan_done_cnt_o = cnt_q;
    assign chan_err_o      = err_q;
    assign chan_irq_o      = irq_q;
    assign busy_o          = ~(&q_empty) | ~trk_empty;

endmodule

// File: tb/tb_eth_idma_chan_sched.sv
// Bench for eth_idma_chan_sched: directed phases plus randomized traffic, checked every cycle
// against a queue-based reference model. A second instance with 2-bit counters shares the
// stimulus so counter wrap is observed as the same completion count modulo 4.
module tb_eth_idma_chan_sched;
    import eth_idma_pkg::*;

    localparam int unsigned NCH = 2;
    localparam int unsigned QD  = 4;
    localparam int unsigned NIF = 4;
    localparam int unsigned CW  = 16;
    localparam int unsigned CWS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst_n;
    eth_idma_req_t [NCH-1:0]  chan_req;
    logic [NCH-1:0]           chan_valid;
    logic [NCH-1:0]           chan_clear;
    logic                     req_ready;
    logic                     rsp_valid;
    eth_idma_rsp_t            idma_rsp;

    logic [NCH-1:0]           chan_ready, chan_ready_s;
    eth_idma_req_t            idma_req, idma_req_s;
    logic                     req_valid, req_valid_s;
    logic                     rsp_ready, rsp_ready_s;
    logic [NCH-1:0][CW-1:0]   cnt;
    logic [NCH-1:0][CWS-1:0]  cnt_s;
    logic [NCH-1:0]           err, err_s, irq, irq_s;
    logic                     busy, busy_s;

    eth_idma_chan_sched #(
        .NumChan (NCH), .QueueDepth (QD), .NumInFlight (NIF), .CntWidth (CW),
        .idma_req_t (eth_idma_req_t), .idma_rsp_t (eth_idma_rsp_t)
    ) dut (
        .clk_i (clk), .rst_ni (rst_n),
        .chan_req_i (chan_req), .chan_valid_i (chan_valid), .chan_ready_o (chan_ready),
        .idma_req_o (idma_req), .req_valid_o (req_valid), .req_ready_i (req_ready),
        .idma_rsp_i (idma_rsp), .rsp_valid_i (rsp_valid), .rsp_ready_o (rsp_ready),
        .chan_clear_i (chan_clear), .chan_done_cnt_o (cnt), .chan_err_o (err),
        .chan_irq_o (irq), .busy_o (busy)
    );

    eth_idma_chan_sched #(
        .NumChan (NCH), .QueueDepth (QD), .NumInFlight (NIF), .CntWidth (CWS),
        .idma_req_t (eth_idma_req_t), .idma_rsp_t (eth_idma_rsp_t)
    ) dut_s (
        .clk_i (clk), .rst_ni (rst_n),
        .chan_req_i (chan_req), .chan_valid_i (chan_valid), .chan_ready_o (chan_ready_s),
        .idma_req_o (idma_req_s), .req_valid_o (req_valid_s), .req_ready_i (req_ready),
        .idma_rsp_i (idma_rsp), .rsp_valid_i (rsp_valid), .rsp_ready_o (rsp_ready_s),
        .chan_clear_i (chan_clear), .chan_done_cnt_o (cnt_s), .chan_err_o (err_s),
        .chan_irq_o (irq_s), .busy_o (busy_s)
    );

    // Reference model: descriptor queues, in-flight channel list, RR pointer, held winner,
    // completions since last clear, sticky error and last-cycle completion flags.
    eth_idma_req_t mq [NCH][$];
    int unsigned   trk [$];
    int unsigned   rr_ptr;
    bit            hold_v;
    int unsigned   hold_ch;
    int unsigned   m_cnt [NCH];
    bit            m_err [NCH];
    bit            m_irq [NCH];

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned exp_winner();
        if (hold_v) return hold_ch;
        for (int unsigned k = 0; k < NCH; k++) begin
            int unsigned c = (rr_ptr + k) % NCH;
            if (mq[c].size() > 0) return c;
        end
        return 0;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) begin
            mq[c].delete();
            m_cnt[c] = 0;
            m_err[c] = 0;
            m_irq[c] = 0;
        end
        trk.delete();
        rr_ptr = 0;
        hold_v = 0;
        hold_ch = 0;
    endtask

    task automatic idle();
        chan_valid = '0;
        chan_clear = '0;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        idma_rsp   = '0;
        for (int c = 0; c < NCH; c++) chan_req[c] = '0;
    endtask

    task automatic rand_inputs(input int unsigned pv, input int unsigned pr, input int unsigned prsp,
                               input int unsigned pclr, input int unsigned perr);
        for (int c = 0; c < NCH; c++) begin
            chan_valid[c] = ($urandom_range(99) < pv);
            chan_clear[c] = ($urandom_range(99) < pclr);
            chan_req[c]   = {$urandom, $urandom, $urandom};
        end
        req_ready      = ($urandom_range(99) < pr);
        rsp_valid      = ($urandom_range(99) < prsp);
        idma_rsp.last  = 1'b1;
        idma_rsp.error = ($urandom_range(99) < perr);
        idma_rsp.pld   = 8'($urandom);
    endtask

    // One clock: compare outputs mid-cycle, advance the model, cross the edge.
    task automatic tick();
        bit             any_q;
        bit             exp_valid;
        int unsigned    w;
        bit             hs_issue;
        bit             hs_rsp;
        int unsigned    rc;
        bit             comp;
        bit [NCH-1:0]   push_ok;
        #4;
        any_q = 0;
        for (int c = 0; c < NCH; c++) if (mq[c].size() > 0) any_q = 1;
        exp_valid = any_q && (trk.size() < NIF);
        w = exp_winner();
        check("req_valid", 128'(req_valid), 128'(exp_valid));
        check("req_valid_s", 128'(req_valid_s), 128'(exp_valid));
        if (exp_valid) check("idma_req", 128'(idma_req), 128'(mq[w][0]));
        check("rsp_ready", 128'(rsp_ready), 128'(trk.size() > 0));
        check("busy", 128'(busy), 128'(any_q || trk.size() > 0));
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("chan_ready%0d", c), 128'(chan_ready[c]), 128'(mq[c].size() < QD));
            check($sformatf("cnt%0d", c), 128'(cnt[c]), 128'(m_cnt[c] % (1 << CW)));
            check($sformatf("cnt_wrap%0d", c), 128'(cnt_s[c]), 128'(m_cnt[c] % (1 << CWS)));
            check($sformatf("err%0d", c), 128'(err[c]), 128'(m_err[c]));
            check($sformatf("irq%0d", c), 128'(irq[c]), 128'(m_irq[c]));
        end

        hs_issue = exp_valid && req_ready;
        hs_rsp   = rsp_valid && (trk.size() > 0);
        for (int c = 0; c < NCH; c++) push_ok[c] = chan_valid[c] && (mq[c].size() < QD);
        rc = hs_rsp ? trk.pop_front() : NCH;
        for (int unsigned c = 0; c < NCH; c++) begin
            comp = hs_rsp && (rc == c);
            if (chan_clear[c]) begin
                m_cnt[c] = comp ? 1 : 0;
                m_err[c] = comp && idma_rsp.error;
            end else if (comp) begin
                m_cnt[c]++;
                m_err[c] = m_err[c] | idma_rsp.error;
            end
            m_irq[c] = comp;
        end
        if (hs_issue) begin
            void'(mq[w].pop_front());
            trk.push_back(w);
            rr_ptr = (w + 1) % NCH;
            hold_v = 0;
        end else if (exp_valid) begin
            hold_v  = 1;
            hold_ch = w;
        end else begin
            hold_v = 0;
        end
        for (int c = 0; c < NCH; c++) if (push_ok[c]) mq[c].push_back(chan_req[c]);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no end, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        model_clear();
        do_reset();

        // Reset state.
        repeat (2) tick();

        // Single descriptor on ch0, length 64.
        chan_valid = 2'b01;
        chan_req[0] = '{src_addr: 32'h0000_1000, dst_addr: 32'h0000_2000, length: 32'd64};
        req_ready = 1'b1;
        tick();
        chan_valid = '0;
        repeat (2) tick();
        rsp_valid = 1'b1;
        tick();
        rsp_valid = 1'b0;
        repeat (3) tick();

        // Fairness: both channels load three descriptors, then drain with responses.
        req_ready = 1'b0;
        repeat (3) begin
            for (int c = 0; c < NCH; c++) chan_req[c] = {$urandom, $urandom, $urandom};
            chan_valid = 2'b11;
            tick();
        end
        chan_valid = '0;
        req_ready = 1'b1;
        rsp_valid = 1'b1;
        repeat (10) tick();
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        tick();

        // Backpressure: winner held while another channel becomes eligible.
        chan_req[0] = {$urandom, $urandom, $urandom};
        chan_valid = 2'b01;
        tick();
        chan_req[1] = {$urandom, $urandom, $urandom};
        chan_valid = 2'b10;
        tick();
        chan_valid = '0;
        repeat (5) tick();
        req_ready = 1'b1;
        repeat (3) tick();
        rsp_valid = 1'b1;
        repeat (4) tick();
        rsp_valid = 1'b0;

        // Tracker full and queue full on ch0.
        for (int i = 0; i < 10; i++) begin
            chan_req[0] = {$urandom, $urandom, $urandom};
            chan_valid = 2'b01;
            tick();
        end
        chan_valid = '0;
        rsp_valid = 1'b1;
        tick();
        rsp_valid = 1'b0;
        repeat (2) tick();
        rsp_valid = 1'b1;
        repeat (15) tick();
        rsp_valid = 1'b0;

        // Error on ch1 is sticky; clear coincident with the next ch1 completion.
        chan_valid = 2'b10;
        chan_req[1] = {$urandom, $urandom, $urandom};
        tick();
        chan_valid = '0;
        tick();
        rsp_valid = 1'b1;
        idma_rsp.error = 1'b1;
        tick();
        rsp_valid = 1'b0;
        idma_rsp.error = 1'b0;
        repeat (3) tick();
        chan_valid = 2'b10;
        chan_req[1] = {$urandom, $urandom, $urandom};
        tick();
        chan_valid = '0;
        tick();
        rsp_valid = 1'b1;
        chan_clear = 2'b10;
        tick();
        rsp_valid = 1'b0;
        chan_clear = '0;
        repeat (2) tick();
        chan_clear = 2'b01;
        tick();
        chan_clear = '0;
        tick();

        // Randomized traffic, reset while busy, then more traffic.
        repeat (300) begin
            rand_inputs(60, 70, 60, 3, 20);
            tick();
        end
        do_reset();
        repeat (2) tick();
        repeat (300) begin
            rand_inputs(40, 50, 80, 2, 10);
            tick();
        end
        repeat (200) begin
            rand_inputs(90, 90, 90, 0, 5);
            tick();
        end
        idle();
        req_ready = 1'b1;
        rsp_valid = 1'b1;
        repeat (20) tick();
        idle();
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
